dezigzag_dequant: RTL
=====================

DEZIGZAG_DEQUANT -- requirements
Module: dezigzag_dequant

Interface
REQ-001 SHALL have parameter AMPLITUDE_PRECISION, default 16: signed width of the incoming coefficient amplitude.
REQ-002 SHALL have parameter COEF_PRECISION, default 16: signed width of the dequantized output coefficient.
REQ-003 i_sysclk  in  1  single clock; all logic on rising edge.
REQ-004 i_arst  in  1  reset, asynchronous, active-high.
REQ-005 i_de  in  1  upstream coefficient beat valid.
REQ-006 i_run_cnt  in  6  1-based zigzag position; value N means index (N-1) mod 64, so 0 means index 63.
REQ-007 i_B  in  AMPLITUDE_PRECISION  signed coefficient amplitude.
REQ-008 o_ready  out  1  stage can accept a beat; drives the upstream i_ready.
REQ-009 i_qt_we / i_qt_addr[5:0] / i_qt_data[7:0]  in  quant-table write port; the address is in zigzag order.
REQ-010 o_blk_valid  out  1  a complete 8x8 block is readable.
REQ-011 i_rd_addr  in  6  natural-order (row*8+col) read address.
REQ-012 o_rd_data  out  COEF_PRECISION  dequantized coefficient; 1-cycle read latency.
REQ-013 i_blk_done  in  1  single-cycle pulse; the consumer releases the current read block.

Function
REQ-014 SHALL hold two 64-entry coefficient banks (ping-pong), a full flag per bank, a write-bank pointer wr_bank, and a read-bank pointer rd_bank.
REQ-015 Beat accepted at a clock edge iff i_de=1 and o_ready=1; no beat is written otherwise (a held stale i_de is never double-written).
REQ-016 o_ready SHALL equal NOT full[wr_bank], from registered state only, with no combinational path from i_de.
REQ-017 On accept: k=(i_run_cnt-1) mod 64; write address = ZZ2NAT[k], the standard JPEG zigzag-to-natural table (k=0->0, 1->1, 2->8, 3->16, 63->63).
REQ-018 Written value = i_B (signed) x QT[k] (unsigned 8-bit), computed at AMPLITUDE_PRECISION+9 bits signed, then saturated to COEF_PRECISION (clip to max positive / min negative).
REQ-019 Accept with k=63 SHALL, at the same edge, set full[wr_bank] and toggle wr_bank.
REQ-020 Block completion SHALL depend only on k=63; missing or repeated indices are not checked, and unwritten entries keep stale contents.
REQ-021 o_blk_valid SHALL equal full[rd_bank].
REQ-022 i_blk_done with o_blk_valid=1 SHALL clear full[rd_bank] and toggle rd_bank; i_blk_done with o_blk_valid=0 is ignored.
REQ-023 Completion of one bank (REQ-019) and release of the other bank (REQ-022) at the same edge SHALL both take effect.
REQ-024 o_rd_data SHALL be registered: value of bank[rd_bank][i_rd_addr] one cycle after the address; reads while o_blk_valid=0 return undefined data.
REQ-025 A write to the same entry in the cycle it is read is impossible by construction: the write and read banks differ whenever o_blk_valid=1.
REQ-026 QT write SHALL update QT[i_qt_addr] at the edge; a same-edge coefficient accept at that index uses the old value.
REQ-027 Steady-state throughput SHALL be one beat per clock while a bank is free.

Reset
REQ-028 While i_arst is high, SHALL set full[1:0]=0, wr_bank=0, rd_bank=0, o_ready=1, o_blk_valid=0, o_rd_data=0, and all 64 QT entries=1 (pass-through).
REQ-029 Reset mid-block SHALL discard the partial block; bank RAM contents are not cleared.
REQ-030 Release of reset SHALL take effect on the next i_sysclk edge with no glitch on o_ready.

Verification
REQ-031 After reset, feed 64 beats with i_run_cnt=1..63,0 and i_B=k -> o_blk_valid=1 next cycle; reading natural address 8 returns 2 and address 16 returns 3.
REQ-032 Load QT[0]=16, then feed a block with i_B=-3 at k=0 and i_B=32767 at k=1 with QT[1]=255 -> natural address 0 returns -48; address 1 returns 32767 (saturated).
REQ-033 Feed 3 blocks back-to-back without i_blk_done -> o_ready drops the cycle after the 128th beat; upstream beat 129 is held until an i_blk_done pulse, then accepted exactly once.
REQ-034 i_blk_done at the same edge as the k=63 beat of the other bank -> o_blk_valid stays 1, rd_bank toggles, no beat is lost.
REQ-035 Assert i_arst after 30 beats -> o_ready=1, o_blk_valid=0, QT all 1; a fresh full block then completes normally in bank 0.

Source files
------------

// File: rtl/dezigzag_dequant.sv
// rtl/dezigzag_dequant.sv - zigzag-to-natural reorder and dequantize into a ping-pong 8x8 coefficient buffer
module dezigzag_dequant #(
    parameter int AMPLITUDE_PRECISION = 16,
    parameter int COEF_PRECISION      = 16
) (
    input  logic                                  i_sysclk,
    input  logic                                  i_arst,
    input  logic                                  i_de,
    input  logic [5:0]                            i_run_cnt,
    input  logic signed [AMPLITUDE_PRECISION-1:0] i_B,
    output logic                                  o_ready,
    input  logic                                  i_qt_we,
    input  logic [5:0]                            i_qt_addr,
    input  logic [7:0]                            i_qt_data,
    output logic                                  o_blk_valid,
    input  logic [5:0]                            i_rd_addr,
    output logic signed [COEF_PRECISION-1:0]      o_rd_data,
    input  logic                                  i_blk_done
);
    localparam int PW = AMPLITUDE_PRECISION + 9;
    localparam logic signed [PW-1:0] MAXV = PW'((64'sd1 <<< (COEF_PRECISION - 1)) - 64'sd1);
    localparam logic signed [PW-1:0] MINV = -MAXV - PW'(1);

    localparam logic [5:0] ZZ2NAT [64] = '{
         0,  1,  8, 16,  9,  2,  3, 10, 17, 24, 32, 25, 18, 11,  4,  5,
        12, 19, 26, 33, 40, 48, 41, 34, 27, 20, 13,  6,  7, 14, 21, 28,
        35, 42, 49, 56, 57, 50, 43, 36, 29, 22, 15, 23, 30, 37, 44, 51,
        58, 59, 52, 45, 38, 31, 39, 46, 53, 60, 61, 54, 47, 55, 62, 63
    };

    logic [1:0]                       full_q, full_d;
    logic                             wr_bank_q, wr_bank_d;
    logic                             rd_bank_q, rd_bank_d;
    logic signed [COEF_PRECISION-1:0] rd_data_q;
    logic [7:0]                       qt_q [64];
    logic signed [COEF_PRECISION-1:0] bank_mem [128];

    logic                             accept, release_blk;
    logic [5:0]                       k;
    logic signed [PW-1:0]             b_ext, qt_ext, prod;
    logic signed [COEF_PRECISION-1:0] coef;

    assign o_ready     = ~full_q[wr_bank_q];
    assign o_blk_valid = full_q[rd_bank_q];
    assign o_rd_data   = rd_data_q;

    // run count is 1-based and wraps, so 0 denotes the last index (63)
    assign k           = i_run_cnt - 6'd1;
    assign accept      = i_de & o_ready;
    assign release_blk = i_blk_done & o_blk_valid;

    assign b_ext  = PW'(i_B);
    assign qt_ext = PW'(qt_q[k]);
    assign prod   = b_ext * qt_ext;

    always_comb begin
        if (prod > MAXV)
            coef = MAXV[COEF_PRECISION-1:0];
        else if (prod < MINV)
            coef = MINV[COEF_PRECISION-1:0];
        else
            coef = prod[COEF_PRECISION-1:0];
    end

    // write and read banks always differ when both a completion and a release occur
    always_comb begin
        full_d    = full_q;
        wr_bank_d = wr_bank_q;
        rd_bank_d = rd_bank_q;
        if (accept && k == 6'd63) begin
            full_d[wr_bank_q] = 1'b1;
            wr_bank_d         = ~wr_bank_q;
        end
        if (release_blk) begin
            full_d[rd_bank_q] = 1'b0;
            rd_bank_d         = ~rd_bank_q;
        end
    end

    always_ff @(posedge i_sysclk or posedge i_arst) begin
        if (i_arst) begin
            full_q    <= 2'b00;
            wr_bank_q <= 1'b0;
            rd_bank_q <= 1'b0;
            rd_data_q <= '0;
            for (int i = 0; i < 64; i++)
                qt_q[i] <= 8'd1;
        end else begin
            full_q    <= full_d;
            wr_bank_q <= wr_bank_d;
            rd_bank_q <= rd_bank_d;
            rd_data_q <= bank_mem[{rd_bank_q, i_rd_addr}];
            if (i_qt_we)
                qt_q[i_qt_addr] <= i_qt_data;
        end
    end

    // coefficient storage survives reset; stale entries are acceptable
    always_ff @(posedge i_sysclk) begin
        if (accept)
            bank_mem[{wr_bank_q, ZZ2NAT[k]}] <= coef;
    end
endmodule
